dram_loader: RTL and testbench

- Writer-side companion to the IR dispatch RAM (DRAM). The IR only reads the DRAM (512 x 15, write enable tied low). This block fills and verifies its contents.
- Accepts console/diagnostic commands over a valid/ready port and generates DRAM write cycles. Entries get odd parity inserted, and the address auto-increments.
- Supports read-back with parity check and a bulk fill (clear) sequence.
- Sits between the diagnostic/console front end and the DRAM write port, ahead of EBOX start.

---
 rtl/dram_pkg.sv | 28 ++
 rtl/dram_loader_if.sv | 28 ++
 rtl/dram_parity_gen.sv | 20 ++
 rtl/dram_loader.sv | 144 ++++++++++++++
 tb/tb_dram_loader.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dram_pkg.sv
// Shared definitions for the IR dispatch RAM (DRAM) and its loader.
// Entry layout, MSB first: A[0:2] B[0:2] P J[1:4] J[7:10].
// The IR read side uses the same field offsets so both ends agree on layout.
package dram_pkg;

    localparam int DRAM_WIDTH     = 15;
    localparam int DRAM_SIZE      = 512;
    localparam int DRAM_ADDR_BITS = $clog2(DRAM_SIZE);

    // Field offsets as little-endian bit indices into the 15-bit entry.
    localparam int A_HI    = 14;
    localparam int A_LO    = 12;
    localparam int B_HI    = 11;
    localparam int B_LO    = 9;
    localparam int P_BIT   = 8;   // index 6 counted from the MSB
    localparam int J_HI_HI = 7;   // J[1:4]
    localparam int J_HI_LO = 4;
    localparam int J_LO_HI = 3;   // J[7:10]
    localparam int J_LO_LO = 0;

    typedef enum logic [1:0] {
        OP_SETADR = 2'b00,
        OP_WRITE  = 2'b01,
        OP_READ   = 2'b10,
        OP_FILL   = 2'b11
    } cmd_op_e;

endpackage

// File: rtl/dram_loader_if.sv
// Console/diagnostic command and read-back response bundle for dram_loader.
// master: command source (console front end); slave: the loader.
//   cmdValid/cmdReady/cmdOp/cmdAddr/cmdData/genPar : command handshake
//   rspValid/rspData/rspParErr                     : read-back result
interface dram_loader_if;
    import dram_pkg::*;

    logic                      cmdValid;
    logic                      cmdReady;
    cmd_op_e                   cmdOp;
    logic [DRAM_ADDR_BITS-1:0] cmdAddr;
    logic [DRAM_WIDTH-1:0]     cmdData;
    logic                      genPar;
    logic                      rspValid;
    logic [DRAM_WIDTH-1:0]     rspData;
    logic                      rspParErr;

    modport master (
        output cmdValid, cmdOp, cmdAddr, cmdData, genPar,
        input  cmdReady, rspValid, rspData, rspParErr
    );

    modport slave (
        input  cmdValid, cmdOp, cmdAddr, cmdData, genPar,
        output cmdReady, rspValid, rspData, rspParErr
    );

endinterface

// File: rtl/dram_parity_gen.sv
// Combinational odd-parity helper for DRAM entries.
//   entry  : 15-bit entry in
//   fixed  : entry with P replaced so the whole word has odd parity
//   odd_ok : 1 when the entry as given already has odd parity
module dram_parity_gen
    import dram_pkg::*;
(
    input  logic [DRAM_WIDTH-1:0] entry,
    output logic [DRAM_WIDTH-1:0] fixed,
    output logic                  odd_ok
);

    always_comb begin
        fixed        = entry;
        // Parity over the other 14 bits: remove P's own contribution.
        fixed[P_BIT] = ~(^entry ^ entry[P_BIT]);
        odd_ok       = ^entry;
    end

endmodule

// File: rtl/dram_loader.sv
// Writer/verifier for the IR dispatch RAM. Takes single commands over the
// cmd interface (SETADR / WRITE / READ / FILL), drives the DRAM write port,
// inserts odd parity on request and checks parity on read-back.
//   clk, reset : clock and asynchronous active-high reset
//   cmd        : command/response interface (slave side)
//   dramAddr   : DRAM address (always the current pointer)
//   dramDin    : DRAM write data, zero except while writing
//   dramWe     : one strobe per written entry
//   dramDout   : DRAM read data, one cycle after address
//   curAddr    : current address pointer
//   busy       : a command is in progress
module dram_loader
    import dram_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    dram_loader_if.slave              cmd,
    output logic [DRAM_ADDR_BITS-1:0] dramAddr,
    output logic [DRAM_WIDTH-1:0]     dramDin,
    output logic                      dramWe,
    input  logic [DRAM_WIDTH-1:0]     dramDout,
    output logic [DRAM_ADDR_BITS-1:0] curAddr,
    output logic                      busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD0,
        S_RD1,
        S_FL
    } state_e;

    state_e                    state_reg, state_next;
    logic [DRAM_ADDR_BITS-1:0] cur_addr_reg, cur_addr_next;
    logic [DRAM_ADDR_BITS-1:0] end_reg, end_next;
    logic [DRAM_WIDTH-1:0]     entry_reg, entry_next;
    logic                      rsp_valid_reg, rsp_valid_next;
    logic [DRAM_WIDTH-1:0]     rsp_data_reg, rsp_data_next;
    logic                      rsp_par_err_reg, rsp_par_err_next;

    // One parity unit shared between write insertion (IDLE, on cmdData)
    // and read check (RD1, on dramDout); the two never happen together.
    logic [DRAM_WIDTH-1:0] par_in;
    logic [DRAM_WIDTH-1:0] par_fixed;
    logic                  par_odd_ok;

    dram_parity_gen u_parity (
        .entry  (par_in),
        .fixed  (par_fixed),
        .odd_ok (par_odd_ok)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= S_IDLE;
            cur_addr_reg    <= '0;
            end_reg         <= '0;
            entry_reg       <= '0;
            rsp_valid_reg   <= 1'b0;
            rsp_data_reg    <= '0;
            rsp_par_err_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            cur_addr_reg    <= cur_addr_next;
            end_reg         <= end_next;
            entry_reg       <= entry_next;
            rsp_valid_reg   <= rsp_valid_next;
            rsp_data_reg    <= rsp_data_next;
            rsp_par_err_reg <= rsp_par_err_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        cur_addr_next    = cur_addr_reg;
        end_next         = end_reg;
        entry_next       = entry_reg;
        rsp_valid_next   = 1'b0;
        rsp_data_next    = rsp_data_reg;
        rsp_par_err_next = rsp_par_err_reg;
        par_in           = cmd.cmdData;
        dramWe           = 1'b0;
        dramDin          = '0;

        case (state_reg)
            S_IDLE: begin
                if (cmd.cmdValid) begin
                    case (cmd.cmdOp)
                        OP_SETADR: cur_addr_next = cmd.cmdAddr;
                        OP_WRITE: begin
                            entry_next = cmd.genPar ? par_fixed : cmd.cmdData;
                            state_next = S_WR;
                        end
                        OP_READ: state_next = S_RD0;
                        OP_FILL: begin
                            entry_next = cmd.genPar ? par_fixed : cmd.cmdData;
                            end_next   = cmd.cmdAddr;
                            state_next = S_FL;
                        end
                        default: state_next = S_IDLE;
                    endcase
                end
            end
            S_WR: begin
                dramWe        = 1'b1;
                dramDin       = entry_reg;
                cur_addr_next = cur_addr_reg + DRAM_ADDR_BITS'(1);
                state_next    = S_IDLE;
            end
            S_RD0: begin
                // Address presented now; DRAM data is valid during RD1.
                state_next = S_RD1;
            end
            S_RD1: begin
                par_in           = dramDout;
                rsp_data_next    = dramDout;
                rsp_par_err_next = ~par_odd_ok;
                rsp_valid_next   = 1'b1;
                cur_addr_next    = cur_addr_reg + DRAM_ADDR_BITS'(1);
                state_next       = S_IDLE;
            end
            S_FL: begin
                dramWe        = 1'b1;
                dramDin       = entry_reg;
                cur_addr_next = cur_addr_reg + DRAM_ADDR_BITS'(1);
                // Natural 9-bit wrap lets end < start run through 511 -> 0.
                if (cur_addr_reg == end_reg) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign dramAddr      = cur_addr_reg;
    assign curAddr       = cur_addr_reg;
    assign busy          = (state_reg != S_IDLE);
    assign cmd.cmdReady  = (state_reg == S_IDLE);
    assign cmd.rspValid  = rsp_valid_reg;
    assign cmd.rspData   = rsp_data_reg;
    assign cmd.rspParErr = rsp_par_err_reg;

endmodule

// File: tb/tb_dram_loader.sv
// Bench for dram_loader: a behavioural DRAM, an abstract reference model of
// the loader (address pointer + memory image), and a scoreboard monitor that
// checks every write strobe and every read-back pulse against queued
// expectations.
module tb_dram_loader;
    import dram_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    dram_loader_if bus ();

    logic [8:0]  dramAddr;
    logic [14:0] dramDin;
    logic        dramWe;
    logic [14:0] dramDout;
    logic [8:0]  curAddr;
    logic        busy;

    dram_loader dut (
        .clk      (clk),
        .reset    (reset),
        .cmd      (bus.slave),
        .dramAddr (dramAddr),
        .dramDin  (dramDin),
        .dramWe   (dramWe),
        .dramDout (dramDout),
        .curAddr  (curAddr),
        .busy     (busy)
    );

    // Behavioural DRAM: synchronous write, one-cycle registered read.
    logic [14:0] ram [512];
    always @(posedge clk) begin
        if (dramWe) ram[dramAddr] <= dramDin;
        dramDout <= ram[dramAddr];
    end

    typedef struct {
        int          addr;
        logic [14:0] data;
    } wr_t;
    typedef struct {
        logic [14:0] data;
        logic        perr;
    } rd_t;

    wr_t wexp[$];
    rd_t rexp[$];

    logic [14:0] m_mem [512];
    int          m_addr = 0;

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: got event expected none/other", name);
    endtask

    // Entry with P chosen so the word holds an odd number of ones.
    function automatic logic [14:0] with_parity(input logic [14:0] w);
        logic [14:0] o;
        o = w & ~15'h0100;
        if ($countones(o) % 2 == 0) o = o | 15'h0100;
        return o;
    endfunction

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (reset) begin
            if (dramWe) fail_now("we_during_reset");
        end else begin
            if (bus.cmdReady == busy) fail_now("ready_equals_busy");
            if (dramWe) begin
                if (wexp.size() == 0) begin
                    fail_now("unexpected_write");
                end else begin
                    wr_t e;
                    e = wexp.pop_front();
                    check("wr_addr", 32'(dramAddr), 32'(e.addr));
                    check("wr_data", 32'(dramDin), 32'(e.data));
                end
            end
            if (bus.rspValid) begin
                if (rexp.size() == 0) begin
                    fail_now("unexpected_rsp");
                end else begin
                    rd_t r;
                    r = rexp.pop_front();
                    check("rsp_data", 32'(bus.rspData), 32'(r.data));
                    check("rsp_parerr", 32'(bus.rspParErr), 32'(r.perr));
                end
            end
        end
    end

    // Drive one command and hold it until accepted.
    task automatic send(input cmd_op_e op, input int addr, input logic [14:0] data, input logic gp);
        int n;
        @(negedge clk);
        bus.cmdValid = 1'b1;
        bus.cmdOp    = op;
        bus.cmdAddr  = addr[8:0];
        bus.cmdData  = data;
        bus.genPar   = gp;
        n = 0;
        while (!bus.cmdReady && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!bus.cmdReady) fail_now("accept_timeout");
        @(posedge clk);
        #1 bus.cmdValid = 1'b0;
    endtask

    // Update the reference model, queue expectations, then send.
    task automatic issue(input cmd_op_e op, input int addr, input logic [14:0] data, input logic gp);
        logic [14:0] w;
        int n;
        w = gp ? with_parity(data) : data;
        case (op)
            OP_SETADR: m_addr = addr;
            OP_WRITE: begin
                wexp.push_back('{addr: m_addr, data: w});
                m_mem[m_addr] = w;
                m_addr = (m_addr + 1) % 512;
            end
            OP_READ: begin
                rexp.push_back('{data: m_mem[m_addr], perr: ($countones(m_mem[m_addr]) % 2 == 0)});
                m_addr = (m_addr + 1) % 512;
            end
            OP_FILL: begin
                n = (addr - m_addr + 512) % 512 + 1;
                for (int i = 0; i < n; i++) begin
                    wexp.push_back('{addr: (m_addr + i) % 512, data: w});
                    m_mem[(m_addr + i) % 512] = w;
                end
                m_addr = (addr + 1) % 512;
            end
            default: ;
        endcase
        send(op, addr, data, gp);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.cmdReady && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (!bus.cmdReady) fail_now("idle_timeout");
        check({name, "_curaddr"}, 32'(curAddr), 32'(m_addr));
        check({name, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic read_at(input int a);
        issue(OP_SETADR, a, 15'h0, 1'b0);
        issue(OP_READ, 0, 15'h0, 1'b0);
    endtask

    initial begin
        int n;
        int cyc;
        for (int i = 0; i < 512; i++) begin
            ram[i]   = 15'h0;
            m_mem[i] = 15'h0;
        end
        bus.cmdValid = 1'b0;
        bus.cmdOp    = OP_SETADR;
        bus.cmdAddr  = '0;
        bus.cmdData  = '0;
        bus.genPar   = 1'b0;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_ready", 32'(bus.cmdReady), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_curaddr", 32'(curAddr), 32'd0);
        check("rst_we", 32'(dramWe), 32'd0);
        check("rst_dramaddr", 32'(dramAddr), 32'd0);
        check("rst_din", 32'(dramDin), 32'd0);
        check("rst_rspvalid", 32'(bus.rspValid), 32'd0);
        check("rst_rspdata", 32'(bus.rspData), 32'd0);
        check("rst_rsperr", 32'(bus.rspParErr), 32'd0);

        // Reset in the middle of a fill, while writing address 37.
        issue(OP_SETADR, 30, 15'h0, 1'b0);
        issue(OP_FILL, 100, 15'h5555, 1'b1);
        n = 0;
        while (curAddr != 9'd37 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("fill_reached_37", 32'(curAddr), 32'd37);
        #2 reset = 1'b1;
        #1;
        check("midrst_we", 32'(dramWe), 32'd0);
        check("midrst_curaddr", 32'(curAddr), 32'd0);
        check("midrst_ready", 32'(bus.cmdReady), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        wexp.delete();
        for (int a = 37; a <= 100; a++) m_mem[a] = 15'h0;
        m_addr = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        read_at(36);
        read_at(37);

        // Write with parity insertion at 0o254.
        issue(OP_SETADR, 9'o254, 15'h0, 1'b0);
        issue(OP_WRITE, 0, 15'h1234, 1'b1);
        wait_idle("wr254");
        read_at(9'o254);

        // Verbatim writes, good and bad parity.
        issue(OP_SETADR, 300, 15'h0, 1'b0);
        issue(OP_WRITE, 0, 15'h7FFF, 1'b0);
        read_at(300);
        issue(OP_SETADR, 301, 15'h0, 1'b0);
        issue(OP_WRITE, 0, 15'h7FFE, 1'b0);
        read_at(301);
        wait_idle("verbatim");

        // Address wrap on consecutive writes.
        issue(OP_SETADR, 510, 15'h0, 1'b0);
        for (int i = 0; i < 3; i++) issue(OP_WRITE, 0, 15'($urandom), 1'($urandom));
        wait_idle("wrap");

        // Full 512-entry clear.
        issue(OP_SETADR, 5, 15'h0, 1'b0);
        issue(OP_FILL, 4, 15'h0, 1'b1);
        cyc = 0;
        n = 0;
        @(negedge clk);
        while (busy && n < 2000) begin
            cyc++;
            n++;
            @(negedge clk);
        end
        check("fill_busy_cycles", 32'(cyc), 32'd512);
        check("fill_curaddr", 32'(curAddr), 32'd5);
        read_at(0);
        read_at(255);
        read_at(511);

        // Command held off during a fill, then accepted exactly once.
        issue(OP_SETADR, 100, 15'h0, 1'b0);
        issue(OP_FILL, 120, 15'h2A2A, 1'b1);
        issue(OP_WRITE, 0, 15'h0F0F, 1'b1);
        wait_idle("held");

        // Randomized command stream.
        for (int i = 0; i < 80; i++) begin
            int op;
            op = $urandom_range(0, 3);
            case (op)
                0: issue(OP_SETADR, $urandom_range(0, 511), 15'h0, 1'b0);
                1: issue(OP_WRITE, 0, 15'($urandom), 1'($urandom));
                2: issue(OP_READ, 0, 15'h0, 1'b0);
                default: issue(OP_FILL, (m_addr + $urandom_range(0, 20)) % 512, 15'($urandom), 1'($urandom));
            endcase
        end
        wait_idle("random");
        for (int i = 0; i < 10; i++) read_at($urandom_range(0, 511));

        // Drain the scoreboard.
        n = 0;
        while ((wexp.size() != 0 || rexp.size() != 0 || busy) && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check("pending_writes", 32'(wexp.size()), 32'd0);
        check("pending_reads", 32'(rexp.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
